// File: rtl/keypad_emulator_pkg.sv
// keypad_defs: constants and types shared by the keypad emulator and the scanner.
// Key codes are packed {col[1:0], row[1:0]}. The scanner's keyreg packing uses the same
// KEY_* constants, so a code written here decodes to the same key there.
package keypad_defs;

    localparam int NUM_ROWS    = 3;
    localparam int NUM_COLS    = 3;
    localparam int KEY_W       = 4;
    localparam int KEY_COL_MSB = 3;
    localparam int KEY_COL_LSB = 2;
    localparam int KEY_ROW_MSB = 1;
    localparam int KEY_ROW_LSB = 0;

    localparam logic [1:0] INVALID_IDX = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } state_e;

    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] key);
        return key[KEY_COL_MSB:KEY_COL_LSB];
    endfunction

    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] key);
        return key[KEY_ROW_MSB:KEY_ROW_LSB];
    endfunction

    // A key is usable only when neither index is the unused value 3.
    function automatic logic key_is_valid(input logic [KEY_W-1:0] key);
        return (key_col(key) != INVALID_IDX) && (key_row(key) != INVALID_IDX);
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: press-command handshake and status of the keypad emulator.
//   cmd_valid / cmd_ready : press request and acceptance (ready only when idle)
//   cmd_key               : {col[1:0], row[1:0]} of the key to press
//   cmd_hold              : solid-closed cycles after bouncing (0 behaves as 1)
//   busy / done / err     : sequence in progress, completion pulse, rejection pulse
// master: command source (scanner-side test driver); slave: the emulator.
interface keypad_emulator_if
    import keypad_defs::*;
#(
    parameter int unsigned CNT_W = 28
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [KEY_W-1:0] cmd_key;
    logic [CNT_W-1:0] cmd_hold;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_key, cmd_hold,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_hold,
        output cmd_ready, busy, done, err
    );

endinterface

// File: rtl/keypad_emulator_contact.sv
// keypad_emulator_contact: registered row drive of the emulated switch matrix.
//   clk, reset : clock, asynchronous active-high reset (row returns to all-ones)
//   contact    : switch of the latched key is closed
//   key_col    : latched column index, key_row : latched row index
//   column     : active-low column strobes from the scanner
//   row        : active-low row returns, one clock after a column or contact change
module keypad_emulator_contact
    import keypad_defs::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                contact,
    input  logic [1:0]          key_col,
    input  logic [1:0]          key_row,
    input  logic [NUM_COLS-1:0] column,
    output logic [NUM_ROWS-1:0] row
);

    logic [NUM_ROWS-1:0] row_d, row_q;
    logic                col_low;

    // Only the latched column matters; other low columns have no closed switch.
    always_comb begin
        col_low = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (int'(key_col) == c) col_low = ~column[c];
        end
        row_d = '1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (contact && col_low && (int'(key_row) == r)) row_d[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) row_q <= '1;
        else       row_q <= row_d;
    end

    assign row = row_q;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of the 3x3 keypad matrix. Accepts a press command,
// closes the matching switch (with optional contact bounce), holds it, releases it
// cleanly and reports completion.
//   clk, reset : clock, asynchronous active-high reset
//   column     : active-low column strobes from the scanner
//   row        : active-low row returns to the scanner
//   cmd        : command handshake and status (keypad_emulator_if.slave)
// Sequence: IDLE -> BOUNCE (BOUNCE_EDGES toggles, BOUNCE_CYCLES apart) -> HOLD
// (max(cmd_hold,1) cycles) -> GAP (BOUNCE_CYCLES open) -> IDLE with done.
module keypad_emulator
    import keypad_defs::*;
#(
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned BOUNCE_EDGES  = 4,
    parameter int unsigned BOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] column,
    output logic [NUM_ROWS-1:0] row,
    keypad_emulator_if.slave    cmd
);

    // Timers count down to 0 inclusive, so an N-cycle state loads N-1.
    localparam logic [CNT_W-1:0] SegLoad =
        CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EdgeLoad =
        CNT_W'((BOUNCE_EDGES == 0) ? 0 : BOUNCE_EDGES - 1);

    function automatic logic [CNT_W-1:0] hold_load(input logic [CNT_W-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic             contact_q, contact_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       key_col_q, key_col_d;
    logic [1:0]       key_row_q, key_row_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            contact_q <= 1'b0;
            timer_q   <= '0;
            edge_q    <= '0;
            hold_q    <= '0;
            key_col_q <= '0;
            key_row_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            contact_q <= contact_d;
            timer_q   <= timer_d;
            edge_q    <= edge_d;
            hold_q    <= hold_d;
            key_col_q <= key_col_d;
            key_row_q <= key_row_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign accept = cmd.cmd_valid && (state_q == IDLE);

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        contact_d = contact_q;
        timer_d   = timer_q;
        edge_d    = edge_q;
        hold_d    = hold_q;
        key_col_d = key_col_q;
        key_row_d = key_row_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                if (accept) begin
                    if (!key_is_valid(cmd.cmd_key)) begin
                        // Rejected keys still complete the handshake but never close a switch.
                        err_d = 1'b1;
                    end else begin
                        key_col_d = key_col(cmd.cmd_key);
                        key_row_d = key_row(cmd.cmd_key);
                        hold_d    = cmd.cmd_hold;
                        contact_d = 1'b1;
                        if (BOUNCE_EDGES == 0) begin
                            state_d = HOLD;
                            timer_d = hold_load(cmd.cmd_hold);
                        end else begin
                            state_d = BOUNCE;
                            timer_d = SegLoad;
                            edge_d  = EdgeLoad;
                        end
                    end
                end
            end
            BOUNCE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (edge_q == '0) begin
                    // The final toggle is forced to closed as HOLD begins.
                    state_d   = HOLD;
                    contact_d = 1'b1;
                    timer_d   = hold_load(hold_q);
                end else begin
                    contact_d = ~contact_q;
                    edge_d    = edge_q - 1'b1;
                    timer_d   = SegLoad;
                end
            end
            HOLD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d   = GAP;
                    contact_d = 1'b0;
                    timer_d   = SegLoad;
                end
            end
            GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        cmd.cmd_ready = (state_q == IDLE);
        cmd.busy      = (state_q != IDLE);
        cmd.done      = done_q;
        cmd.err       = err_q;
    end

    keypad_emulator_contact u_contact (
        .clk     (clk),
        .reset   (reset),
        .contact (contact_q),
        .key_col (key_col_q),
        .key_row (key_row_q),
        .column  (column),
        .row     (row)
    );

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (clean press and 4-edge bounce) share the
// column bus and command stimulus; a timeline model predicts row/ready/busy/done/err.
module tb_keypad_emulator;

    localparam int CW = 28;
    localparam int BC = 8;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] column = 3'b111;
    logic [2:0] row0, row4;
    logic [6:0] obs0, obs4;

    keypad_emulator_if #(.CNT_W(CW)) cmd0 ();
    keypad_emulator_if #(.CNT_W(CW)) cmd4 ();

    keypad_emulator #(.CNT_W(CW), .BOUNCE_EDGES(0), .BOUNCE_CYCLES(BC)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .column (column),
        .row    (row0),
        .cmd    (cmd0.slave)
    );

    keypad_emulator #(.CNT_W(CW), .BOUNCE_EDGES(4), .BOUNCE_CYCLES(BC)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .column (column),
        .row    (row4),
        .cmd    (cmd4.slave)
    );

    always #5 clk = ~clk;

    assign obs0 = {row0, cmd0.cmd_ready, cmd0.busy, cmd0.done, cmd0.err};
    assign obs4 = {row4, cmd4.cmd_ready, cmd4.busy, cmd4.done, cmd4.err};

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: each press is a timeline relative to its accept cycle t0.
    int         edges_p[2] = '{0, 4};
    bit         act[2];
    int         t0[2];
    int         hold_m[2];
    int         kc[2];
    int         kr[2];
    int         err_at[2];
    bit         pcon[2];
    logic [2:0] pcol;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int total_len(input int i);
        return edges_p[i] * BC + hold_m[i] + BC;
    endfunction

    // Contact closed in cycle c: bounce segments alternate starting closed, then hold.
    function automatic bit contact_at(input int i, input int c);
        int k, b;
        if (!act[i]) return 1'b0;
        k = c - t0[i];
        b = edges_p[i] * BC;
        if (k < 1) return 1'b0;
        if (k <= b) return (((k - 1) / BC) % 2) == 0;
        if (k <= b + hold_m[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]    = 1'b0;
            pcon[i]   = 1'b0;
            err_at[i] = -1;
            kc[i]     = 0;
            kr[i]     = 0;
        end
        pcol = column;
    endtask

    // One clock: check outputs of the current cycle, advance the model, drive inputs.
    task automatic step(input bit v, input logic [3:0] key, input logic [27:0] hold,
                        input logic [2:0] col);
        logic [6:0] obs;
        logic [2:0] erow;
        bit         ebusy, edone, eerr, con;
        int         k;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs   = (i == 0) ? obs0 : obs4;
            k     = cyc - t0[i];
            ebusy = act[i] && (k >= 1) && (k <= total_len(i));
            edone = act[i] && (k == total_len(i) + 1);
            eerr  = (err_at[i] == cyc);
            erow  = 3'b111;
            if (pcon[i] && !pcol[kc[i]]) erow[kr[i]] = 1'b0;
            check($sformatf("dut%0d.row", edges_p[i]),   32'(obs[6:4]), 32'(erow));
            check($sformatf("dut%0d.ready", edges_p[i]), 32'(obs[3]),   32'(!ebusy));
            check($sformatf("dut%0d.busy", edges_p[i]),  32'(obs[2]),   32'(ebusy));
            check($sformatf("dut%0d.done", edges_p[i]),  32'(obs[1]),   32'(edone));
            check($sformatf("dut%0d.err", edges_p[i]),   32'(obs[0]),   32'(eerr));
            con = contact_at(i, cyc);
            if (edone) act[i] = 1'b0;
            if (v && !ebusy) begin
                if (key[3:2] == 2'd3 || key[1:0] == 2'd3) begin
                    err_at[i] = cyc + 1;
                end else begin
                    act[i]    = 1'b1;
                    t0[i]     = cyc;
                    hold_m[i] = (hold == 0) ? 1 : int'(hold);
                    kc[i]     = int'(key[3:2]);
                    kr[i]     = int'(key[1:0]);
                end
            end
            pcon[i] = con;
        end
        cmd0.cmd_valid = v;
        cmd0.cmd_key   = key;
        cmd0.cmd_hold  = hold;
        cmd4.cmd_valid = v;
        cmd4.cmd_key   = key;
        cmd4.cmd_hold  = hold;
        column         = col;
        pcol           = col;
        cyc++;
    endtask

    // Reset pulse between clock edges; row and busy must clear before the next edge.
    task automatic mid_reset();
        cmd0.cmd_valid = 1'b0;
        cmd4.cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async.row0",  32'(row0),      32'h7);
        check("async.row4",  32'(row4),      32'h7);
        check("async.busy0", 32'(cmd0.busy), 32'h0);
        check("async.busy4", 32'(cmd4.busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    logic [2:0] sweep[3] = '{3'b110, 3'b101, 3'b011};

    initial begin
        logic [3:0] rkey;
        cmd0.cmd_valid = 1'b0;
        cmd0.cmd_key   = '0;
        cmd0.cmd_hold  = '0;
        cmd4.cmd_valid = 1'b0;
        cmd4.cmd_key   = '0;
        cmd4.cmd_hold  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle column sweep.
        for (int j = 0; j < 9; j++) step(1'b0, 4'h0, 28'd0, sweep[j % 3]);

        // col1,row2 for 20 cycles; a request during HOLD is ignored, and a request held
        // through the clean instance's done cycle is accepted there.
        step(1'b1, 4'b0110, 28'd20, sweep[0]);
        for (int j = 1; j < 75; j++) begin
            if (j == 10)                step(1'b1, 4'b0000, 28'd5, sweep[j % 3]);
            else if (j >= 26 && j <= 29) step(1'b1, 4'b0001, 28'd3, sweep[j % 3]);
            else                         step(1'b0, 4'h0, 28'd0, sweep[j % 3]);
        end

        // Bounce pattern on col0,row0 with the column held low.
        step(1'b1, 4'b0000, 28'd10, 3'b110);
        for (int j = 0; j < 60; j++) step(1'b0, 4'h0, 28'd0, 3'b110);

        // Invalid column and row indices.
        step(1'b1, 4'b1100, 28'd5, 3'b110);
        for (int j = 0; j < 3; j++) step(1'b0, 4'h0, 28'd0, 3'b110);
        step(1'b1, 4'b0011, 28'd5, 3'b000);
        for (int j = 0; j < 3; j++) step(1'b0, 4'h0, 28'd0, 3'b000);

        // Reset in the middle of HOLD, then a fresh command.
        step(1'b1, 4'b0000, 28'd30, 3'b110);
        for (int j = 0; j < 6; j++) step(1'b0, 4'h0, 28'd0, 3'b110);
        check("prereset.row0", 32'(row0), 32'h6);
        mid_reset();
        step(1'b1, 4'b0110, 28'd4, 3'b101);
        for (int j = 0; j < 50; j++) step(1'b0, 4'h0, 28'd0, 3'b101);

        // Random traffic.
        for (int j = 0; j < 800; j++) begin
            rkey = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                 : {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            step($urandom_range(0, 3) == 0, rkey, 28'($urandom_range(0, 12)), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
